// File: rtl/sram_bridge.sv
// Byte-bus responder on a 16-bit async SRAM; reads land in i_data WAIT+2 clk after an address change.
// No backpressure: accesses always run to completion, and locked holds the CPU off until power-up delay expires.
module sram_bridge #(
  parameter int WAIT       = 1,
  parameter int LOCK_DELAY = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  o_data,
  input  logic        wr,
  output logic [7:0]  i_data,
  output logic        locked,
  output logic [18:0] sram_a,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  localparam int CW = $clog2(LOCK_DELAY + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_DELAY - 1);
  localparam logic          WAIT_LAST = 1'(WAIT);

  typedef enum logic [1:0] {LOCK, IDLE, READ, WRITE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            wait_cnt_q, wait_cnt_d;
  logic            locked_q, locked_d;
  logic [7:0]      i_data_q, i_data_d;
  logic [19:0]     acc_addr_q, acc_addr_d;
  logic [19:0]     last_addr_q, last_addr_d;
  logic            valid_q, valid_d;
  logic [15:0]     dq_o_q, dq_o_d;
  logic            dq_oe_q, dq_oe_d;
  logic            ce_n_q, ce_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            lb_n_q, lb_n_d;
  logic            ub_n_q, ub_n_d;

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    locked_d    = locked_q;
    i_data_d    = i_data_q;
    acc_addr_d  = acc_addr_q;
    last_addr_d = last_addr_q;
    valid_d     = valid_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = 1'b0;
    ce_n_d      = 1'b1;
    oe_n_d      = 1'b1;
    we_n_d      = 1'b1;
    lb_n_d      = 1'b1;
    ub_n_d      = 1'b1;

    case (state_q)
      LOCK: begin
        lock_cnt_d = lock_cnt_q + CW'(1);
        if (lock_cnt_q == LOCK_LAST) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end
      end
      IDLE: begin
        wait_cnt_d = 1'b0;
        if (wr) begin
          acc_addr_d = address;
          dq_o_d     = {o_data, o_data};
          state_d    = WRITE;
        end else if (!valid_q || address != last_addr_q) begin
          acc_addr_d = address;
          state_d    = READ;
        end
      end
      READ: begin
        if (wait_cnt_q == WAIT_LAST) begin
          i_data_d    = acc_addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
          last_addr_d = acc_addr_q;
          valid_d     = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        if (wait_cnt_q == WAIT_LAST) begin
          // Drop the cached byte so the next IDLE re-reads what was just written.
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = LOCK;
    endcase

    // Strobes follow the state being entered so they are registered with it.
    if (state_d == READ || state_d == WRITE) begin
      ce_n_d  = 1'b0;
      oe_n_d  = (state_d != READ);
      we_n_d  = (state_d != WRITE);
      dq_oe_d = (state_d == WRITE);
      lb_n_d  = acc_addr_d[0];
      ub_n_d  = ~acc_addr_d[0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOCK;
      lock_cnt_q  <= '0;
      wait_cnt_q  <= 1'b0;
      locked_q    <= 1'b0;
      i_data_q    <= '0;
      acc_addr_q  <= '0;
      last_addr_q <= '0;
      valid_q     <= 1'b0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      locked_q    <= locked_d;
      i_data_q    <= i_data_d;
      acc_addr_q  <= acc_addr_d;
      last_addr_q <= last_addr_d;
      valid_q     <= valid_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
    end
  end

  assign i_data     = i_data_q;
  assign locked     = locked_q;
  assign sram_a     = acc_addr_q[19:1];
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_lb_n  = lb_n_q;
  assign sram_ub_n  = ub_n_q;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed and randomised bench for sram_bridge with WAIT=1 and WAIT=0 instances on shared stimulus.
module tb_sram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr;
  logic [19:0] address;
  logic [7:0]  o_data;
  logic [15:0] seed;

  logic [7:0]  i_data1, i_data0;
  logic        locked1, locked0;
  logic [18:0] a1, a0;
  logic [15:0] dq_i1, dq_i0, dq_o1, dq_o0;
  logic        dq_oe1, dq_oe0;
  logic        ce_n1, oe_n1, we_n1, lb_n1, ub_n1;
  logic        ce_n0, oe_n0, we_n0, lb_n0, ub_n0;

  int checks = 0;
  int errors = 0;
  int bad_ce = 0;

  logic [15:0] mem1 [256];
  logic [15:0] mem0 [256];
  logic [7:0]  ref_b [512];

  always #5 clk = ~clk;

  sram_bridge #(.WAIT(1), .LOCK_DELAY(16)) dut1 (
    .clk(clk), .reset(reset), .address(address), .o_data(o_data), .wr(wr),
    .i_data(i_data1), .locked(locked1), .sram_a(a1), .sram_dq_i(dq_i1),
    .sram_dq_o(dq_o1), .sram_dq_oe(dq_oe1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1),
    .sram_we_n(we_n1), .sram_lb_n(lb_n1), .sram_ub_n(ub_n1)
  );

  sram_bridge #(.WAIT(0), .LOCK_DELAY(4)) dut0 (
    .clk(clk), .reset(reset), .address(address), .o_data(o_data), .wr(wr),
    .i_data(i_data0), .locked(locked0), .sram_a(a0), .sram_dq_i(dq_i0),
    .sram_dq_o(dq_o0), .sram_dq_oe(dq_oe0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
    .sram_we_n(we_n0), .sram_lb_n(lb_n0), .sram_ub_n(ub_n0)
  );

  function automatic logic [15:0] init_word(input int i, input logic [15:0] s);
    int t;
    if (s == 16'h0) begin
      case (i)
        8'h10:   return 16'h1234;
        8'h20:   return 16'h0077;
        8'hFF:   return 16'hBEEF;
        default: return 16'h0000;
      endcase
    end
    t = (i * 40503) ^ (int'(s) * 7) ^ (i << 9);
    return t[15:0];
  endfunction

  // Asynchronous SRAM models; contents are reloaded from init_word while reset is high.
  assign dq_i1 = (!ce_n1 && !oe_n1) ? mem1[a1[7:0]] : 16'hxxxx;
  assign dq_i0 = (!ce_n0 && !oe_n0) ? mem0[a0[7:0]] : 16'hxxxx;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_word(i, seed);
        mem0[i] <= init_word(i, seed);
      end
    end else begin
      if (!ce_n1 && !we_n1 && dq_oe1) begin
        if (!lb_n1) mem1[a1[7:0]][7:0]  <= dq_o1[7:0];
        if (!ub_n1) mem1[a1[7:0]][15:8] <= dq_o1[15:8];
      end
      if (!ce_n0 && !we_n0 && dq_oe0) begin
        if (!lb_n0) mem0[a0[7:0]][7:0]  <= dq_o0[7:0];
        if (!ub_n0) mem0[a0[7:0]][15:8] <= dq_o0[15:8];
      end
    end
  end

  always @(negedge clk) begin
    if ((!locked1 && !ce_n1) || (!locked0 && !ce_n0)) bad_ce++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes1();
    return {ce_n1, oe_n1, we_n1, lb_n1, ub_n1};
  endfunction

  initial begin
    logic [19:0] ra;
    logic [7:0]  rd;
    logic [15:0] w;

    reset = 1'b1; wr = 1'b0; address = '0; o_data = '0; seed = 16'h0;
    tick(); tick();
    check("reset_i_data", i_data1, 8'h00);
    check("reset_locked", locked1, 1'b0);
    check("reset_strobes", strobes1(), 5'b11111);
    check("reset_dq_oe", dq_oe1, 1'b0);

    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("lock_edge%0d", k), locked1, (k == 16));
      if (k == 15) begin
        check("lock_strobes", strobes1(), 5'b11111);
        check("lock_i_data", i_data1, 8'h00);
      end
    end
    repeat (4) tick();

    // Low-lane read of word 0x10.
    address = 20'h00020;
    tick();
    check("rd20_strobes", strobes1(), 5'b00101);
    check("rd20_sram_a", a1, 19'h00010);
    tick();
    check("rd20_not_yet", i_data1, 8'h00);
    tick();
    check("rd20_data", i_data1, 8'h34);
    check("rd20_ce_off", ce_n1, 1'b1);

    address = 20'h00021;
    tick();
    check("rd21_strobes", strobes1(), 5'b00110);
    tick(); tick();
    check("rd21_data", i_data1, 8'h12);

    // One-clk write to odd address, then the forced re-read.
    wr = 1'b1; address = 20'h00041; o_data = 8'hA5;
    tick();
    wr = 1'b0;
    check("wr_strobes", strobes1(), 5'b01010);
    check("wr_dq_oe", dq_oe1, 1'b1);
    check("wr_sram_a", a1, 19'h00020);
    check("wr_dq_o", dq_o1, 16'hA5A5);
    tick();
    check("wr_we_2nd", we_n1, 1'b0);
    check("wr_i_data_hold", i_data1, 8'h12);
    tick();
    check("wr_we_done", we_n1, 1'b1);
    tick(); tick(); tick();
    check("raw_data", i_data1, 8'hA5);
    check("raw_mem_word", mem1[8'h20], 16'hA577);
    address = 20'h00040;
    tick(); tick(); tick();
    check("rd40_low_kept", i_data1, 8'h77);

    // Address moves during the second READ cycle.
    address = 20'h00020;
    tick();
    address = 20'h00021;
    tick(); tick();
    check("chg_old_byte", i_data1, 8'h34);
    check("chg_gap", ce_n1, 1'b1);
    tick();
    check("chg_new_strobes", strobes1(), 5'b00110);
    tick(); tick();
    check("chg_new_byte", i_data1, 8'h12);

    // Top of address space.
    address = 20'hFFFFF;
    tick();
    check("wrap_sram_a", a1, 19'h7FFFF);
    check("wrap_strobes", strobes1(), 5'b00110);
    tick(); tick();
    check("wrap_data", i_data1, 8'hBE);

    // Reset in the middle of a write.
    wr = 1'b1; address = 20'h00041; o_data = 8'h5A;
    tick();
    check("rstwr_we", we_n1, 1'b0);
    reset = 1'b1;
    tick();
    check("rstwr_strobes", strobes1(), 5'b11111);
    check("rstwr_dq_oe", dq_oe1, 1'b0);
    check("rstwr_locked", locked1, 1'b0);
    check("rstwr_i_data", i_data1, 8'h00);
    reset = 1'b0; wr = 1'b0; address = '0;
    repeat (15) tick();
    check("relock_early", locked1, 1'b0);
    tick();
    check("relock", locked1, 1'b1);

    // Random reads/writes against a reference byte array on both instances.
    reset = 1'b1; seed = 16'h5A3C;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      w = init_word(i, seed);
      ref_b[2*i]   = w[7:0];
      ref_b[2*i+1] = w[15:8];
    end
    repeat (20) tick();
    for (int n = 0; n < 200; n++) begin
      ra = 20'($urandom_range(0, 511));
      if ($urandom_range(0, 2) == 0) begin
        rd = 8'($urandom_range(0, 255));
        wr = 1'b1; address = ra; o_data = rd;
        ref_b[ra[8:0]] = rd;
        tick();
        wr = 1'b0;
        repeat (5) tick();
      end else begin
        address = ra;
        tick(); tick();
        check($sformatf("rand_w0_%0d", n), i_data0, ref_b[ra[8:0]]);
        tick();
        check($sformatf("rand_w1_%0d", n), i_data1, ref_b[ra[8:0]]);
      end
    end
    check("no_ce_while_unlocked", bad_ce, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
